multi_timer_ctrl: RTL and testbench
===================================

Name: multi_timer_ctrl

Overview:
Parametrised multi-channel stopwatch/countdown controller. It generalises the single IDLE/RUNNING/PAUSED control FSM to NUM_CH independent channels. Each channel adds an up/down mode, a loadable count, terminal-count detection and a DONE state. A shared prescaler produces the count tick. The block sits between the debounced button/host-register layer and the display/interrupt logic.

Parameters:
NUM_CH, 4, number of independent timer channels
CNT_W, 16, per-channel count width in bits
PRESCALE, 1000, clk cycles per count tick (>=1; 1 means a tick every cycle)

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
sync_reset  input  1  synchronous global clear, all channels plus prescaler
start  input  NUM_CH  per-channel start/resume pulse
stop  input  NUM_CH  per-channel pause pulse
clear  input  NUM_CH  per-channel return to IDLE
mode  input  NUM_CH  0 = count up, 1 = count down; sampled only on start from IDLE/DONE
load_val  input  NUM_CH*CNT_W  down-mode start value; ch i occupies bits [i*CNT_W +: CNT_W]
count  output  NUM_CH*CNT_W  current count per channel, same packing
status  output  2*NUM_CH  per-channel state: 00 IDLE, 01 RUNNING, 10 PAUSED, 11 DONE
en  output  NUM_CH  1 when the channel is RUNNING
done_pulse  output  NUM_CH  one-cycle pulse when the channel enters DONE
tick  output  1  prescaler tick, one clk wide

Behaviour:
- Reset (rst_n low, asynchronous): all states IDLE, count 0, mode latch 0, done_pulse 0, tick 0, prescaler 0.
- Prescaler:
  - Free-running counter over 0..PRESCALE-1.
  - tick is registered and is high for one cycle when the counter wraps.
  - sync_reset zeroes the counter and tick, so the first tick comes PRESCALE cycles after sync_reset deasserts.
- Per-channel priority, high to low: sync_reset > clear > stop > start > tick.
- sync_reset or clear: state IDLE, count 0, next cycle.
- IDLE or DONE + start:
  - Latch mode.
  - Load count: 0 for up mode, load_val for down mode.
  - Enter RUNNING.
  - Exception: down mode with load_val == 0 enters DONE directly with count 0.
- RUNNING:
  - Without a tick: hold.
  - On tick, up mode: count+1. If the new count is all-ones, enter DONE.
  - On tick, down mode: count-1. If the new count is 0, enter DONE.
  - No wrap-around in either direction.
- RUNNING + stop: enter PAUSED, count held. A coincident tick is discarded.
- PAUSED + start: enter RUNNING with count and latched mode retained. The mode input is ignored here.
- Ignored inputs:
  - stop in IDLE, PAUSED or DONE.
  - start in RUNNING.
  - start+stop together in PAUSED or IDLE: start wins.
- DONE: count held, ticks ignored. start restarts the channel as from IDLE; clear returns it to IDLE.
- Outputs:
  - status mirrors the state register.
  - en = (state == RUNNING), combinational from the registered state.
  - done_pulse is registered and high exactly in the first cycle status reads 11.
- Channels are fully independent and share only tick.
- rst_n asserted mid-operation clears everything immediately, with no clock required.

Decomposition:
- Shared header timer_defs.vh: state encodings ST_IDLE/ST_RUNNING/ST_PAUSED/ST_DONE and mode encodings MODE_UP/MODE_DOWN.
- Sub-module timer_channel (param CNT_W): one FSM plus count register plus done_pulse.
- The top holds the prescaler and a generate loop of NUM_CH timer_channel instances.

Test Plan:
(All scenarios use NUM_CH=2, CNT_W=4, PRESCALE=3.)
1. Up count and pause:
   - ch0 mode=0, start, wait 10 ticks (30 clk) -> count0=10, status0=01, en0=1.
   - stop -> status0=10, count0 holds 10 for 9 clk.
   - start -> resumes; next tick gives 11.
2. Countdown to DONE:
   - ch1 mode=1, load_val=3, start -> count1=3.
   - After 3 ticks -> count1=0, status1=11, done_pulse1 high for exactly 1 clk, en1=0.
   - Further ticks -> count1 stays 0.
3. Up-mode saturation:
   - ch0 up for 15 ticks -> count0=15, status0=11, done_pulse0 once.
   - start -> count0=0, status0=01.
4. Simultaneous events:
   - stop on the same cycle as tick while RUNNING at 5 -> status 10, count 5.
   - start+stop together in PAUSED -> status 01.
   - clear+start together -> status 00, count 0.
5. Resets mid-run:
   - sync_reset with both channels RUNNING -> next cycle both status 00, count 0; first tick exactly 3 clk after release.
   - rst_n low asynchronously mid-cycle -> outputs 0 immediately.
6. Zero load: down mode with load_val=0, start -> status 11 next cycle, done_pulse 1 cycle, count 0.

Source files
------------

// File: rtl/multi_timer_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// multi_timer_ctrl_pkg
//
// Purpose: shared definitions for the multi-channel stopwatch/countdown
// controller. It holds the channel state encoding (also the external status
// encoding), the count-direction encoding and a prescaler width helper.
//
// Ports: none (package).
// -----------------------------------------------------------------------------
package multi_timer_ctrl_pkg;

  // The encoding is the one seen on the status output, so do not reorder.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUNNING = 2'b01,
    ST_PAUSED  = 2'b10,
    ST_DONE    = 2'b11
  } state_e;

  typedef enum logic {
    MODE_UP   = 1'b0,
    MODE_DOWN = 1'b1
  } mode_e;

  // Width of the prescaler counter. It is at least one bit, so that
  // PRESCALE == 1 still gets a legal vector. In that case the counter is
  // held at 0 and a tick occurs on every cycle.
  function automatic int ps_width(input int prescale);
    return (prescale > 1) ? $clog2(prescale) : 1;
  endfunction

endpackage

// File: rtl/multi_timer_ctrl_timer_channel.sv
// -----------------------------------------------------------------------------
// timer_channel
//
// Purpose: one independent timer channel. It contains the
// IDLE/RUNNING/PAUSED/DONE control FSM, the count register, the latched count
// direction and a registered done_pulse.
//
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   sync_reset   - synchronous clear (highest priority)
//   tick         - shared count tick from the prescaler, one clk wide
//   start        - start/resume pulse
//   stop         - pause pulse
//   clear        - return to IDLE
//   mode         - 0 up / 1 down; sampled only on start from IDLE/DONE
//   load_val     - start value for down mode
//   count        - current count
//   status       - current state (state_e encoding)
//   en           - 1 while RUNNING
//   done_pulse   - high in the first cycle status reads DONE
//
// Command priority, high to low: sync_reset > clear > stop > start > tick.
// The control inputs are level-sampled on every clk edge. There is no
// handshake: a one-cycle pulse is one command.
// -----------------------------------------------------------------------------
module timer_channel
  import multi_timer_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sync_reset,
  input  logic             tick,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             mode,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic [1:0]       status,
  output logic             en,
  output logic             done_pulse
);

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             done_pulse_q, done_pulse_d;

  // The candidate count for the next tick. Terminal count is detected on
  // this value, so the channel stops at all-ones or at zero and never wraps.
  logic [CNT_W-1:0] stepped;
  logic             stepped_terminal;

  assign stepped = (mode_q == MODE_UP) ? (count_q + CNT_ONE) : (count_q - CNT_ONE);
  assign stepped_terminal = (mode_q == MODE_UP) ? (stepped == CNT_MAX)
                                                : (stepped == CNT_ZERO);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      mode_q       <= MODE_UP;
      count_q      <= '0;
      done_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      count_q      <= count_d;
      done_pulse_q <= done_pulse_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    count_d = count_q;

    if (sync_reset || clear) begin
      state_d = ST_IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        // DONE restarts exactly like IDLE. In this state stop is ignored, so
        // when start and stop arrive together, start wins.
        ST_IDLE, ST_DONE: begin
          if (start) begin
            mode_d = mode_e'(mode);
            if (mode_e'(mode) == MODE_DOWN) begin
              count_d = load_val;
              // A zero load has nothing to count, so it finishes at once.
              state_d = (load_val == CNT_ZERO) ? ST_DONE : ST_RUNNING;
            end else begin
              count_d = '0;
              state_d = ST_RUNNING;
            end
          end
        end

        // stop takes priority and discards a tick on the same cycle.
        // start is ignored in this state.
        ST_RUNNING: begin
          if (stop) begin
            state_d = ST_PAUSED;
          end else if (tick) begin
            count_d = stepped;
            if (stepped_terminal) begin
              state_d = ST_DONE;
            end
          end
        end

        // Resume keeps the count and the latched direction. The mode input
        // is not looked at here.
        ST_PAUSED: begin
          if (start) begin
            state_d = ST_RUNNING;
          end
        end

        default: begin
          state_d = ST_IDLE;
          count_d = '0;
        end
      endcase
    end

    // The pulse is registered, so it lines up with the first cycle in which
    // status shows DONE.
    done_pulse_d = (state_d == ST_DONE) && (state_q != ST_DONE);
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    count      = count_q;
    status     = state_q;
    en         = (state_q == ST_RUNNING);
    done_pulse = done_pulse_q;
  end

endmodule

// File: rtl/multi_timer_ctrl.sv
// -----------------------------------------------------------------------------
// multi_timer_ctrl
//
// Purpose: NUM_CH independent stopwatch/countdown channels. All channels
// share one prescaler that produces a one-clk count tick every PRESCALE
// cycles.
//
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   sync_reset   - synchronous clear of all channels and the prescaler
//   start/stop/clear/mode [NUM_CH]   - per-channel controls
//   load_val [NUM_CH*CNT_W]          - down-mode start values, ch i at
//                                      [i*CNT_W +: CNT_W]
//   count [NUM_CH*CNT_W]             - per-channel counts, same packing
//   status [2*NUM_CH]                - per-channel state, ch i at [2*i +: 2]
//                                      (00 IDLE, 01 RUNNING, 10 PAUSED,
//                                       11 DONE)
//   en [NUM_CH]                      - channel RUNNING
//   done_pulse [NUM_CH]              - one-cycle pulse on entry to DONE
//   tick                             - prescaler tick, one clk wide
// -----------------------------------------------------------------------------
module multi_timer_ctrl
  import multi_timer_ctrl_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 16,
  parameter int PRESCALE = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sync_reset,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH-1:0]       stop,
  input  logic [NUM_CH-1:0]       clear,
  input  logic [NUM_CH-1:0]       mode,
  input  logic [NUM_CH*CNT_W-1:0] load_val,
  output logic [NUM_CH*CNT_W-1:0] count,
  output logic [2*NUM_CH-1:0]     status,
  output logic [NUM_CH-1:0]       en,
  output logic [NUM_CH-1:0]       done_pulse,
  output logic                    tick
);

  localparam int              PS_W    = ps_width(PRESCALE);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [PS_W-1:0] PS_ONE  = PS_W'(1);

  logic [PS_W-1:0] ps_cnt;
  logic            tick_q;

  // The prescaler runs freely over 0..PRESCALE-1. The tick is registered on
  // the wrap. Because of that, after a sync_reset the first tick appears
  // PRESCALE cycles after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_cnt <= '0;
      tick_q <= 1'b0;
    end else if (sync_reset) begin
      ps_cnt <= '0;
      tick_q <= 1'b0;
    end else if (ps_cnt == PS_LAST) begin
      ps_cnt <= '0;
      tick_q <= 1'b1;
    end else begin
      ps_cnt <= ps_cnt + PS_ONE;
      tick_q <= 1'b0;
    end
  end

  assign tick = tick_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    timer_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .sync_reset(sync_reset),
      .tick      (tick_q),
      .start     (start[i]),
      .stop      (stop[i]),
      .clear     (clear[i]),
      .mode      (mode[i]),
      .load_val  (load_val[i*CNT_W +: CNT_W]),
      .count     (count[i*CNT_W +: CNT_W]),
      .status    (status[2*i +: 2]),
      .en        (en[i]),
      .done_pulse(done_pulse[i])
    );
  end

endmodule

// File: tb/tb_multi_timer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multi_timer_ctrl
//
// Directed scenarios followed by a randomized phase. All of them are checked
// every cycle against a behavioural model. The model keeps each channel as
// integer state/count/direction and the prescaler as a cycle counter. Extra
// spot checks compare against constant values taken from the timer rules.
// -----------------------------------------------------------------------------
module tb_multi_timer_ctrl;

  localparam int NUM_CH   = 2;
  localparam int CNT_W    = 4;
  localparam int PRESCALE = 3;
  localparam int CMAX     = (1 << CNT_W) - 1;

  // Model state codes, as read on status.
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    sync_reset;
  logic [NUM_CH-1:0]       start, stop, clear, mode;
  logic [NUM_CH*CNT_W-1:0] load_val;
  logic [NUM_CH*CNT_W-1:0] count;
  logic [2*NUM_CH-1:0]     status;
  logic [NUM_CH-1:0]       en, done_pulse;
  logic                    tick;

  int checks = 0;
  int errors = 0;

  // Reference model.
  int m_state[NUM_CH];
  int m_count[NUM_CH];
  int m_mode[NUM_CH];
  bit m_dp[NUM_CH];
  int m_ps;
  bit m_tick;
  bit m_consumed;   // a tick was presented at the last clock edge

  multi_timer_ctrl #(
    .NUM_CH  (NUM_CH),
    .CNT_W   (CNT_W),
    .PRESCALE(PRESCALE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sync_reset(sync_reset),
    .start     (start),
    .stop      (stop),
    .clear     (clear),
    .mode      (mode),
    .load_val  (load_val),
    .count     (count),
    .status    (status),
    .en        (en),
    .done_pulse(done_pulse),
    .tick      (tick)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Comparison helper
  // ---------------------------------------------------------------------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_state[c] = S_IDLE;
      m_count[c] = 0;
      m_mode[c]  = 0;
      m_dp[c]    = 1'b0;
    end
    m_ps       = 0;
    m_tick     = 1'b0;
    m_consumed = 1'b0;
  endtask

  task automatic model_edge();
    bit t;
    int old;
    int lv;
    if (!rst_n) begin
      model_reset();
      return;
    end
    t = m_tick;
    m_consumed = t;
    for (int c = 0; c < NUM_CH; c++) begin
      old = m_state[c];
      lv  = int'(load_val[c*CNT_W +: CNT_W]);
      if (sync_reset || clear[c]) begin
        m_state[c] = S_IDLE;
        m_count[c] = 0;
      end else if (old == S_IDLE || old == S_DONE) begin
        if (start[c]) begin
          m_mode[c] = int'(mode[c]);
          if (m_mode[c] == 1) begin
            m_count[c] = lv;
            m_state[c] = (lv == 0) ? S_DONE : S_RUN;
          end else begin
            m_count[c] = 0;
            m_state[c] = S_RUN;
          end
        end
      end else if (old == S_RUN) begin
        if (stop[c]) begin
          m_state[c] = S_PAUSE;
        end else if (t) begin
          if (m_mode[c] == 0) begin
            m_count[c] = m_count[c] + 1;
            if (m_count[c] == CMAX) m_state[c] = S_DONE;
          end else begin
            m_count[c] = m_count[c] - 1;
            if (m_count[c] == 0) m_state[c] = S_DONE;
          end
        end
      end else begin
        if (start[c]) m_state[c] = S_RUN;
      end
      m_dp[c] = (m_state[c] == S_DONE) && (old != S_DONE);
    end
    if (sync_reset) begin
      m_ps   = 0;
      m_tick = 1'b0;
    end else begin
      m_tick = (m_ps == PRESCALE - 1);
      m_ps   = (m_ps + 1) % PRESCALE;
    end
  endtask

  task automatic check_outputs();
    logic [NUM_CH*CNT_W-1:0] e_count;
    logic [2*NUM_CH-1:0]     e_status;
    logic [NUM_CH-1:0]       e_en, e_dp;
    for (int c = 0; c < NUM_CH; c++) begin
      e_count[c*CNT_W +: CNT_W] = CNT_W'(m_count[c]);
      e_status[2*c +: 2]        = 2'(m_state[c]);
      e_en[c]                   = (m_state[c] == S_RUN);
      e_dp[c]                   = m_dp[c];
    end
    chk("model_count", 32'(count), 32'(e_count));
    chk("model_status", 32'(status), 32'(e_status));
    chk("model_en", 32'(en), 32'(e_en));
    chk("model_done_pulse", 32'(done_pulse), 32'(e_dp));
    chk("model_tick", 32'(tick), 32'(m_tick));
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic idle_inputs();
    sync_reset = 1'b0;
    start      = '0;
    stop       = '0;
    clear      = '0;
  endtask

  // Run until n clock edges have each consumed a tick.
  task automatic wait_ticks(input int n);
    int seen = 0;
    for (int k = 0; k < n * PRESCALE + PRESCALE && seen < n; k++) begin
      step();
      if (m_consumed) seen++;
    end
  endtask

  // Run until a tick is presented for the next edge.
  task automatic wait_tick_pending();
    for (int k = 0; k < PRESCALE + 1 && !m_tick; k++) step();
  endtask

  function automatic int cnt_of(input int c);
    return int'(count[c*CNT_W +: CNT_W]);
  endfunction

  function automatic int st_of(input int c);
    return int'(status[2*c +: 2]);
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int d;
    rst_n    = 1'b0;
    idle_inputs();
    mode     = '0;
    load_val = '0;
    model_reset();
    #12;
    check_outputs();
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_status", 32'(status), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1. Up count and pause
    sync_reset = 1'b1; step(); sync_reset = 1'b0;
    mode[0] = 1'b0; start[0] = 1'b1; step(); start[0] = 1'b0;
    wait_ticks(10);
    chk("s1_count10", cnt_of(0), 10);
    chk("s1_running", st_of(0), 1);
    chk("s1_en", 32'(en[0]), 1);
    stop[0] = 1'b1; step(); stop[0] = 1'b0;
    chk("s1_paused", st_of(0), 2);
    repeat (9) step();
    chk("s1_hold", cnt_of(0), 10);
    start[0] = 1'b1; step(); start[0] = 1'b0;
    wait_ticks(1);
    chk("s1_resume", cnt_of(0), 11);

    // 2. Countdown to DONE
    mode[1] = 1'b1; load_val[7:4] = 4'd3; start[1] = 1'b1; step(); start[1] = 1'b0;
    chk("s2_load", cnt_of(1), 3);
    wait_ticks(3);
    chk("s2_zero", cnt_of(1), 0);
    chk("s2_done", st_of(1), 3);
    chk("s2_pulse", 32'(done_pulse[1]), 1);
    chk("s2_en", 32'(en[1]), 0);
    step();
    chk("s2_pulse_once", 32'(done_pulse[1]), 0);
    wait_ticks(2);
    chk("s2_stays0", cnt_of(1), 0);

    // 3. Up-mode saturation
    clear[0] = 1'b1; step(); clear[0] = 1'b0;
    mode[0] = 1'b0; start[0] = 1'b1; step(); start[0] = 1'b0;
    wait_ticks(14);
    chk("s3_14", cnt_of(0), 14);
    wait_ticks(1);
    chk("s3_15", cnt_of(0), 15);
    chk("s3_done", st_of(0), 3);
    chk("s3_pulse", 32'(done_pulse[0]), 1);
    step();
    chk("s3_pulse_once", 32'(done_pulse[0]), 0);
    start[0] = 1'b1; step(); start[0] = 1'b0;
    chk("s3_restart_cnt", cnt_of(0), 0);
    chk("s3_restart_st", st_of(0), 1);

    // 4. Simultaneous events
    wait_ticks(5);
    chk("s4_at5", cnt_of(0), 5);
    wait_tick_pending();
    stop[0] = 1'b1; step(); stop[0] = 1'b0;
    chk("s4_stop_tick_st", st_of(0), 2);
    chk("s4_stop_tick_cnt", cnt_of(0), 5);
    step();
    start[0] = 1'b1; stop[0] = 1'b1; step(); idle_inputs();
    chk("s4_start_stop", st_of(0), 1);
    clear[0] = 1'b1; start[0] = 1'b1; step(); idle_inputs();
    chk("s4_clear_start_st", st_of(0), 0);
    chk("s4_clear_start_cnt", cnt_of(0), 0);

    // 5. Resets mid-run
    mode = 2'b10; load_val = {4'd9, 4'd0}; start = 2'b11; step(); start = '0;
    repeat (4) step();
    sync_reset = 1'b1; step(); sync_reset = 1'b0;
    chk("s5_sr_status", 32'(status), 0);
    chk("s5_sr_count", 32'(count), 0);
    chk("s5_sr_tick", 32'(tick), 0);
    d = 0;
    do begin
      step();
      d++;
    end while (!tick && d < 10);
    chk("s5_first_tick", d, PRESCALE);
    start = 2'b11; step(); start = '0;
    repeat (5) step();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("s5_async_count", 32'(count), 0);
    chk("s5_async_status", 32'(status), 0);
    chk("s5_async_en", 32'(en), 0);
    chk("s5_async_dp", 32'(done_pulse), 0);
    chk("s5_async_tick", 32'(tick), 0);
    step();
    rst_n = 1'b1;

    // 6. Zero load in down mode
    mode[0] = 1'b1; load_val[3:0] = 4'd0; start[0] = 1'b1; step(); start[0] = 1'b0;
    chk("s6_done", st_of(0), 3);
    chk("s6_pulse", 32'(done_pulse[0]), 1);
    chk("s6_count", cnt_of(0), 0);
    step();
    chk("s6_pulse_once", 32'(done_pulse[0]), 0);

    // Randomized phase
    for (int n = 0; n < 800; n++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        start[c] = ($urandom_range(0, 5) == 0);
        stop[c]  = ($urandom_range(0, 7) == 0);
        clear[c] = ($urandom_range(0, 29) == 0);
        mode[c]  = 1'($urandom_range(0, 1));
        load_val[c*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, CMAX));
      end
      sync_reset = ($urandom_range(0, 149) == 0);
      step();
    end
    idle_inputs();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
